// File: rtl/fetch_pkg.sv
// Shared state encoding and default parameters for the instruction fetch unit.
package fetch_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_STEP  = 4;
endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads instruction memory with one
// outstanding request and hands words to decode through a one-entry output slot.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned       PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc
);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_nxt;
    logic [ADDR_W-1:0] pc_inc;
    logic              req_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              valid_nxt;
    logic [DATA_W-1:0] out_nxt;
    logic [ADDR_W-1:0] instr_pc_nxt;
    logic              transfer;
    logic              slot_free;
    logic              pending;

    assign transfer  = instr_valid && instr_ready;
    assign slot_free = !instr_valid || instr_ready;
    assign pending   = imem_req && !imem_ack;
    assign pc_inc    = fetch_pc + STEP;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            imem_req    <= req_nxt;
            imem_addr   <= addr_nxt;
            instr_valid <= valid_nxt;
            instr_out   <= out_nxt;
            instr_pc    <= instr_pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                if (redirect_valid)
                    state_nxt = imem_ack ? FETCH : DRAIN;
                else if (imem_ack && !slot_free)
                    state_nxt = STALL;
            end
            STALL: begin
                if (redirect_valid || transfer)
                    state_nxt = FETCH;
            end
            DRAIN: begin
                if (imem_ack)
                    state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fetch_pc_nxt = fetch_pc;
        req_nxt      = imem_req;
        addr_nxt     = imem_addr;
        valid_nxt    = instr_valid && !instr_ready;
        out_nxt      = instr_out;
        instr_pc_nxt = instr_pc;
        if (redirect_valid) begin
            // An in-flight read keeps its address until acked; DRAIN throws it away.
            fetch_pc_nxt = redirect_pc;
            valid_nxt    = 1'b0;
            if (!pending) begin
                req_nxt  = 1'b1;
                addr_nxt = redirect_pc;
            end
        end else begin
            case (state)
                IDLE: begin
                    req_nxt  = 1'b1;
                    addr_nxt = fetch_pc;
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (slot_free) begin
                            out_nxt      = imem_rdata;
                            instr_pc_nxt = imem_addr;
                            valid_nxt    = 1'b1;
                            fetch_pc_nxt = pc_inc;
                            addr_nxt     = pc_inc;
                        end else begin
                            // Slot still occupied: drop the word, refetch it after the stall.
                            req_nxt = 1'b0;
                        end
                    end
                end
                STALL: begin
                    if (transfer) begin
                        req_nxt  = 1'b1;
                        addr_nxt = fetch_pc;
                    end
                end
                DRAIN: begin
                    if (imem_ack)
                        addr_nxt = fetch_pc;
                end
                default: req_nxt = 1'b0;
            endcase
        end
    end
endmodule
